// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI register-write controller and its users.
package spi_pkg;

  localparam int SPI_FRAME_W = 16;
  localparam int SPI_ADDR_W  = 7;

  // Register map of the on-chip SPI register peripheral
  localparam logic [SPI_ADDR_W-1:0] ADDR_EN_OUT_LO = 7'h00;
  localparam logic [SPI_ADDR_W-1:0] ADDR_EN_OUT_HI = 7'h01;
  localparam logic [SPI_ADDR_W-1:0] ADDR_EN_PWM_LO = 7'h02;
  localparam logic [SPI_ADDR_W-1:0] ADDR_EN_PWM_HI = 7'h03;
  localparam logic [SPI_ADDR_W-1:0] ADDR_PWM_DUTY  = 7'h04;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    SHIFT_LO,
    SHIFT_HI,
    HOLD,
    GAP
  } spi_ctrl_state_t;

  function automatic int spi_max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/spi_controller_if.sv
// Command handshake between a host command source and the SPI controller.
interface spi_controller_if;

  logic                          cmd_valid;
  logic                          cmd_ready;
  logic                          cmd_rw;
  logic [spi_pkg::SPI_ADDR_W-1:0] cmd_addr;
  logic [7:0]                    cmd_data;

  modport master (
    output cmd_valid, cmd_rw, cmd_addr, cmd_data,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid, cmd_rw, cmd_addr, cmd_data,
    output cmd_ready
  );

endinterface

// File: rtl/spi_phase_timer.sv
// Loadable down-counter timing every fixed-length controller state; saturates at zero.
module spi_phase_timer #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         expire
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign expire = (cnt == '0);

endmodule

// File: rtl/spi_controller.sv
// Write-only SPI initiator: serialises {rw, addr, data} as a mode-0 MSB-first frame.
module spi_controller
  import spi_pkg::*;
#(
  parameter int CLK_DIV  = 4,
  parameter int CS_SETUP = 4,
  parameter int CS_GAP   = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  spi_controller_if.slave        cmd,
  output logic                   busy,
  output logic                   done,
  output logic                   ncs,
  output logic                   sclk,
  output logic                   copi
);

  localparam int TW    = $clog2(spi_max3(CLK_DIV, CS_SETUP, CS_GAP) + 1);
  localparam int BCW   = $clog2(SPI_FRAME_W);
  localparam logic [TW-1:0] LD_SETUP = TW'(CS_SETUP - 1);
  localparam logic [TW-1:0] LD_HALF  = TW'(CLK_DIV - 1);
  localparam logic [TW-1:0] LD_GAP   = TW'(CS_GAP - 1);

  spi_ctrl_state_t        state, state_next;
  logic [SPI_FRAME_W-1:0] shift_q, shift_next;
  logic [BCW-1:0]         bit_cnt, bit_cnt_next;
  logic                   ready_q;
  logic                   accept;
  logic                   expire;
  logic                   load;
  logic [TW-1:0]          load_val;
  logic                   cs_active_next;

  assign cmd.cmd_ready = ready_q;
  assign accept        = cmd.cmd_valid && ready_q;

  spi_phase_timer #(.W(TW)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .load_val (load_val),
    .expire   (expire)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      shift_q <= '0;
      bit_cnt <= '0;
    end else begin
      state   <= state_next;
      shift_q <= shift_next;
      bit_cnt <= bit_cnt_next;
    end
  end

  // The timer is reloaded on every state change with the length of the state being entered
  always_comb begin
    state_next   = state;
    shift_next   = shift_q;
    bit_cnt_next = bit_cnt;
    load_val     = '0;
    case (state)
      IDLE: begin
        if (accept) begin
          shift_next   = {cmd.cmd_rw, cmd.cmd_addr, cmd.cmd_data};
          bit_cnt_next = BCW'(SPI_FRAME_W - 1);
          state_next   = SETUP;
        end
      end
      SETUP:    if (expire) state_next = SHIFT_HI;
      SHIFT_HI: begin
        if (expire) begin
          if (bit_cnt == '0) begin
            state_next = HOLD;
          end else begin
            bit_cnt_next = bit_cnt - 1'b1;
            shift_next   = {shift_q[SPI_FRAME_W-2:0], 1'b0};
            state_next   = SHIFT_LO;
          end
        end
      end
      SHIFT_LO: if (expire) state_next = SHIFT_HI;
      HOLD:     if (expire) state_next = GAP;
      GAP:      if (expire) state_next = IDLE;
      default:  state_next = IDLE;
    endcase
    load = (state_next != state);
    case (state_next)
      SETUP, HOLD:        load_val = LD_SETUP;
      SHIFT_LO, SHIFT_HI: load_val = LD_HALF;
      GAP:                load_val = LD_GAP;
      default:            load_val = '0;
    endcase
  end

  assign cs_active_next = (state_next == SETUP) || (state_next == SHIFT_LO) ||
                          (state_next == SHIFT_HI) || (state_next == HOLD);

  // Pins and status are registered from the next state so they align with the state register
  always_ff @(posedge clk) begin
    if (rst) begin
      ready_q <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      ncs     <= 1'b1;
      sclk    <= 1'b0;
      copi    <= 1'b0;
    end else begin
      ready_q <= (state_next == IDLE);
      busy    <= (state_next != IDLE);
      done    <= (state == HOLD) && (state_next == GAP);
      ncs     <= !cs_active_next;
      sclk    <= (state_next == SHIFT_HI);
      copi    <= cs_active_next ? shift_next[SPI_FRAME_W-1] : 1'b0;
    end
  end

endmodule

// File: tb/tb_spi_controller.sv
// Self-checking bench for spi_controller with a behavioural model of the SPI register peripheral.
module tb_spi_controller;
  import spi_pkg::*;

  localparam int CLK_DIV  = 4;
  localparam int CS_SETUP = 4;
  localparam int CS_GAP   = 4;
  localparam int BUDGET   = 400;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic busy, done, ncs, sclk, copi;

  spi_controller_if cmd_if ();

  spi_controller #(.CLK_DIV(CLK_DIV), .CS_SETUP(CS_SETUP), .CS_GAP(CS_GAP)) dut (
    .clk  (clk),
    .rst  (rst),
    .cmd  (cmd_if),
    .busy (busy),
    .done (done),
    .ncs  (ncs),
    .sclk (sclk),
    .copi (copi)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Peripheral model and pin-timing monitor, sampled mid-cycle
  logic [7:0]  preg [0:127];
  logic        mon_en = 1'b0;
  logic        prev_ncs = 1'b1, prev_sclk = 1'b0, prev_copi = 1'b0;
  logic [15:0] fsh = '0;
  logic [15:0] last_frame = '0;
  logic        prev_complete = 1'b0;
  int edges = 0, run = 1, frames = 0, aborted = 0, done_cnt = 0, tvio = 0;
  int last_gap = 0, ncs_fall_cyc = 0, done_cyc = 0;

  always @(negedge clk) begin
    if (mon_en) begin
      if ({ncs, sclk} == {prev_ncs, prev_sclk}) begin
        run++;
      end else begin
        if (!(ncs && edges != 16)) begin
          if (!prev_ncs && prev_sclk) begin
            if (run != CLK_DIV) tvio++;
          end else if (!prev_ncs && !prev_sclk) begin
            if (edges == 0 || ncs) begin
              if (run != CS_SETUP) tvio++;
            end else if (run != CLK_DIV) begin
              tvio++;
            end
          end else if (!ncs) begin
            last_gap = run;
            if (prev_complete && run < CS_GAP) tvio++;
          end
        end
        run = 1;
      end
      if (!ncs && prev_ncs) begin
        edges = 0;
        fsh = '0;
        ncs_fall_cyc = cyc;
      end
      if (!ncs && sclk && !prev_sclk) begin
        edges++;
        fsh = {fsh[14:0], copi};
        if (edges > 16) tvio++;
      end
      if (!ncs && sclk && prev_sclk && copi != prev_copi) tvio++;
      if (ncs && (sclk || copi)) tvio++;
      if (ncs && !prev_ncs) begin
        if (edges == 16) begin
          last_frame = fsh;
          frames++;
          prev_complete = 1'b1;
          if (fsh[15]) preg[fsh[14:8]] = fsh[7:0];
        end else begin
          aborted++;
          prev_complete = 1'b0;
        end
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
        if (!(ncs && !prev_ncs && edges == 16)) tvio++;
      end
    end else begin
      run = 1;
      prev_complete = 1'b0;
    end
    prev_ncs  = ncs;
    prev_sclk = sclk;
    prev_copi = copi;
  end

  typedef struct {
    string       name;
    logic        rw;
    logic [6:0]  addr;
    logic [7:0]  data;
    logic [15:0] exp_frame;
    logic [6:0]  reg_addr;
    logic [7:0]  exp_reg;
  } vec_t;

  vec_t vecs [5];
  int   t_acc;

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  // Presents one command, waits for the handshake, then drops cmd_valid
  task automatic applyStimulus(input logic rw, input logic [6:0] addr, input logic [7:0] data);
    int n;
    cmd_if.cmd_valid = 1'b1;
    cmd_if.cmd_rw    = rw;
    cmd_if.cmd_addr  = addr;
    cmd_if.cmd_data  = data;
    n = 0;
    while (!cmd_if.cmd_ready && n < BUDGET) begin
      tick();
      n++;
    end
    checkOutput("accept_timeout", 32'(cmd_if.cmd_ready), 32'd1);
    t_acc = cyc;
    tick();
    cmd_if.cmd_valid = 1'b0;
  endtask

  task automatic waitDone(input int target);
    int n;
    n = 0;
    while (done_cnt < target && n < BUDGET) begin
      tick();
      n++;
    end
    checkOutput("done_timeout", 32'(done_cnt >= target), 32'd1);
  endtask

  initial begin
    int d0, a0;
    int n;
    for (int i = 0; i < 128; i++) preg[i] = 8'h00;
    cmd_if.cmd_valid = 1'b0;
    cmd_if.cmd_rw    = 1'b0;
    cmd_if.cmd_addr  = '0;
    cmd_if.cmd_data  = '0;

    vecs[0] = '{"single_write", 1'b1, ADDR_PWM_DUTY, 8'h80, 16'h8480, ADDR_PWM_DUTY, 8'h80};
    vecs[1] = '{"read_flag",    1'b0, ADDR_EN_PWM_LO, 8'hFF, 16'h02FF, ADDR_EN_PWM_LO, 8'h00};
    vecs[2] = '{"write_a55",    1'b1, 7'h55, 8'hAA, 16'hD5AA, 7'h55, 8'hAA};
    vecs[3] = '{"write_a7f",    1'b1, 7'h7F, 8'h01, 16'hFF01, 7'h7F, 8'h01};
    vecs[4] = '{"write_a01",    1'b1, ADDR_EN_OUT_HI, 8'h5A, 16'h815A, ADDR_EN_OUT_HI, 8'h5A};

    repeat (3) tick();
    checkOutput("rst_ncs",   32'(ncs), 32'd1);
    checkOutput("rst_sclk",  32'(sclk), 32'd0);
    checkOutput("rst_copi",  32'(copi), 32'd0);
    checkOutput("rst_ready", 32'(cmd_if.cmd_ready), 32'd0);
    checkOutput("rst_busy",  32'(busy), 32'd0);
    checkOutput("rst_done",  32'(done), 32'd0);
    rst = 1'b0;
    mon_en = 1'b1;
    tick();
    checkOutput("ready_after_rst", 32'(cmd_if.cmd_ready), 32'd1);

    foreach (vecs[i]) begin
      d0 = done_cnt;
      applyStimulus(vecs[i].rw, vecs[i].addr, vecs[i].data);
      checkOutput({vecs[i].name, "_busy"}, 32'(busy), 32'd1);
      waitDone(d0 + 1);
      repeat (CS_GAP + 2) tick();
      checkOutput({vecs[i].name, "_frame"}, 32'(last_frame), 32'(vecs[i].exp_frame));
      checkOutput({vecs[i].name, "_reg"}, 32'(preg[vecs[i].reg_addr]), 32'(vecs[i].exp_reg));
      checkOutput({vecs[i].name, "_done_once"}, 32'(done_cnt - d0), 32'd1);
      checkOutput({vecs[i].name, "_ncs_lat"}, 32'(ncs_fall_cyc - t_acc), 32'd1);
      checkOutput({vecs[i].name, "_done_lat"}, 32'(done_cyc - t_acc), 32'd133);
    end

    // Back-to-back frames with cmd_valid held high throughout
    d0 = done_cnt;
    cmd_if.cmd_valid = 1'b1;
    cmd_if.cmd_rw    = 1'b1;
    cmd_if.cmd_addr  = ADDR_EN_OUT_LO;
    cmd_if.cmd_data  = 8'hA5;
    n = 0;
    while (!cmd_if.cmd_ready && n < BUDGET) begin tick(); n++; end
    tick();
    cmd_if.cmd_addr = ADDR_EN_OUT_HI;
    cmd_if.cmd_data = 8'h3C;
    n = 0;
    while (!cmd_if.cmd_ready && n < BUDGET) begin tick(); n++; end
    checkOutput("b2b_second_accept", 32'(cmd_if.cmd_ready), 32'd1);
    tick();
    cmd_if.cmd_valid = 1'b0;
    waitDone(d0 + 2);
    repeat (CS_GAP + 2) tick();
    checkOutput("b2b_reg0", 32'(preg[ADDR_EN_OUT_LO]), 32'hA5);
    checkOutput("b2b_reg1", 32'(preg[ADDR_EN_OUT_HI]), 32'h3C);
    checkOutput("b2b_frame2", 32'(last_frame), 32'h813C);
    checkOutput("b2b_gap_ok", 32'(last_gap >= CS_GAP), 32'd1);

    // Reset at the 8th rising sclk edge aborts the frame without done
    d0 = done_cnt;
    a0 = aborted;
    applyStimulus(1'b1, ADDR_PWM_DUTY, 8'h3C);
    n = 0;
    while (edges < 8 && n < BUDGET) begin tick(); n++; end
    checkOutput("abort_edge8", 32'(edges), 32'd8);
    rst = 1'b1;
    tick();
    checkOutput("abort_ncs",  32'(ncs), 32'd1);
    checkOutput("abort_sclk", 32'(sclk), 32'd0);
    checkOutput("abort_done", 32'(done), 32'd0);
    rst = 1'b0;
    repeat (3) tick();
    checkOutput("abort_count", 32'(aborted - a0), 32'd1);
    checkOutput("abort_no_done", 32'(done_cnt - d0), 32'd0);
    checkOutput("abort_reg_kept", 32'(preg[ADDR_PWM_DUTY]), 32'h80);
    applyStimulus(1'b1, ADDR_EN_PWM_HI, 8'h11);
    waitDone(d0 + 1);
    repeat (CS_GAP + 2) tick();
    checkOutput("post_abort_frame", 32'(last_frame), 32'h8311);
    checkOutput("post_abort_reg", 32'(preg[ADDR_EN_PWM_HI]), 32'h11);

    // Command inputs change while busy; the latched frame is sent
    d0 = done_cnt;
    applyStimulus(1'b1, ADDR_PWM_DUTY, 8'h5A);
    n = 0;
    while (edges < 4 && n < BUDGET) begin tick(); n++; end
    cmd_if.cmd_rw   = 1'b0;
    cmd_if.cmd_addr = 7'h7E;
    cmd_if.cmd_data = 8'hC3;
    waitDone(d0 + 1);
    repeat (CS_GAP + 2) tick();
    checkOutput("busy_change_frame", 32'(last_frame), 32'h845A);
    checkOutput("busy_change_reg", 32'(preg[ADDR_PWM_DUTY]), 32'h5A);

    checkOutput("pin_timing_violations", 32'(tvio), 32'd0);
    checkOutput("total_aborted", 32'(aborted), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
